// File: rtl/denoise_pkg.sv
// Shared types and sizing helpers for the stream_denoise binary window filter.
package denoise_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef enum logic {
        MODE_COUNT = 1'b0,
        MODE_GATED = 1'b1
    } mode_e;

    // Width able to hold a population count of a full n_size x n_size window.
    function automatic int unsigned sum_w(input int unsigned n_size);
        return $clog2(n_size * n_size + 1);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: read-before-write at a shared column address.
module line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are never reset; the window mask hides anything stale.
    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/stream_denoise.sv
// Streaming NxN binary neighbourhood-count filter with per-color thresholds,
// frame framing from in_sof, and a zero-fed flush to drain the last rows.
module stream_denoise
    import denoise_pkg::*;
#(
    parameter int unsigned N_SIZE = 5,
    parameter int unsigned COLORS = 1,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    localparam int unsigned SUM_W = sum_w(N_SIZE),
    localparam int unsigned XW    = $clog2(IMG_W),
    localparam int unsigned YW    = $clog2(IMG_H)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [COLORS-1:0]       in_pix,
    input  logic [COLORS*SUM_W-1:0] n_threshold,
    input  logic                    mode,
    output logic                    out_valid,
    output logic [COLORS-1:0]       out_pix,
    output logic [XW-1:0]           out_x,
    output logic [YW-1:0]           out_y,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic                    busy
);

    localparam int unsigned R   = N_SIZE / 2;
    localparam int unsigned D   = R * IMG_W + R;
    localparam int unsigned PW  = $clog2(D + 1);
    localparam int unsigned YIW = $clog2(IMG_H + 1);
    localparam int unsigned NL  = N_SIZE - 1;

    typedef logic [N_SIZE-1:0][N_SIZE-1:0][COLORS-1:0] win_t;

    state_e state_q, state_d;
    logic [XW-1:0]  in_x_q, in_x_d, cur_x;
    logic [YIW-1:0] in_y_q, in_y_d, cur_y;
    logic [PW-1:0]  prime_q, prime_d, prime_base;
    logic [PW-1:0]  flush_q, flush_d;
    logic [XW-1:0]  ox_q, ox_d;
    logic [YW-1:0]  oy_q, oy_d;
    win_t           win_q, win_d, win_base;

    logic beat, restart, step, emit;
    logic [COLORS-1:0]               pix_in, pix_c;
    logic [NL-1:0][COLORS-1:0]       lb_wr, lb_rd;
    logic [N_SIZE-1:0][COLORS-1:0]   row_in;
    logic [N_SIZE-1:0][N_SIZE-1:0]   mask_c;
    logic [COLORS-1:0][SUM_W-1:0]    cnt_c;

    logic              out_valid_q, out_valid_d;
    logic [COLORS-1:0] out_pix_q, out_pix_d;
    logic [XW-1:0]     out_x_q, out_x_d;
    logic [YW-1:0]     out_y_q, out_y_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (restart) state_d = ST_RUN;
            ST_RUN:   if (beat && !in_sof && in_x_q == XW'(IMG_W - 1)
                          && in_y_q == YIW'(IMG_H - 1)) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_q == PW'(D - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q != ST_FLUSH);
        busy     = (state_q != ST_IDLE);
    end

    // Beat qualification; a start-of-frame beat rebuilds from a clean slate.
    always_comb begin
        beat       = in_valid && in_ready;
        restart    = beat && in_sof;
        step       = restart || (state_q == ST_RUN && beat) || (state_q == ST_FLUSH);
        pix_in     = (state_q == ST_FLUSH) ? '0 : in_pix;
        cur_x      = restart ? '0 : in_x_q;
        cur_y      = restart ? '0 : in_y_q;
        prime_base = restart ? '0 : prime_q;
        win_base   = restart ? '0 : win_q;
        emit       = step && (prime_base == PW'(D));
    end

    generate
        for (genvar m = 0; m < int'(NL); m++) begin : g_lb
            if (m == 0) begin : g_head
                assign lb_wr[m] = pix_in;
            end else begin : g_tail
                assign lb_wr[m] = lb_rd[m-1];
            end
            line_buffer #(
                .DEPTH (IMG_W),
                .WIDTH (COLORS)
            ) u_lb (
                .clk   (clk),
                .we    (step),
                .addr  (cur_x),
                .wdata (lb_wr[m]),
                .rdata (lb_rd[m])
            );
        end
    endgenerate

    // Newest row comes straight from the input, older rows from the buffer chain.
    always_comb begin
        row_in = '0;
        row_in[N_SIZE-1] = pix_in;
        for (int i = 0; i < int'(NL); i++) begin
            row_in[i] = lb_rd[int'(NL) - 1 - i];
        end
    end

    // Counters and window shift
    always_comb begin
        in_x_d  = in_x_q;
        in_y_d  = in_y_q;
        prime_d = prime_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        win_d   = win_q;
        flush_d = (state_q == ST_FLUSH) ? flush_q + PW'(1) : '0;
        if (restart) begin
            ox_d = '0;
            oy_d = '0;
        end
        if (step) begin
            in_x_d  = (cur_x == XW'(IMG_W - 1)) ? '0 : cur_x + XW'(1);
            in_y_d  = (state_q != ST_FLUSH && cur_x == XW'(IMG_W - 1)) ? cur_y + YIW'(1) : cur_y;
            prime_d = (prime_base == PW'(D)) ? prime_base : prime_base + PW'(1);
            for (int i = 0; i < int'(N_SIZE); i++) begin
                for (int j = 0; j < int'(N_SIZE) - 1; j++) begin
                    win_d[i][j] = win_base[i][j+1];
                end
                win_d[i][N_SIZE-1] = row_in[i];
            end
        end
        if (emit) begin
            ox_d = (ox_q == XW'(IMG_W - 1)) ? '0 : ox_q + XW'(1);
            if (ox_q == XW'(IMG_W - 1)) begin
                oy_d = (oy_q == YW'(IMG_H - 1)) ? '0 : oy_q + YW'(1);
            end
        end
    end

    // Window taps landing outside the frame for the emitted pixel are ignored.
    always_comb begin
        int col;
        int row;
        mask_c = '0;
        for (int i = 0; i < int'(N_SIZE); i++) begin
            for (int j = 0; j < int'(N_SIZE); j++) begin
                col = int'(ox_q) + j - int'(R);
                row = int'(oy_q) + i - int'(R);
                mask_c[i][j] = (col >= 0) && (col < int'(IMG_W)) && (row >= 0) && (row < int'(IMG_H));
            end
        end
    end

    // Per-color population count and threshold compare
    always_comb begin
        cnt_c = '0;
        pix_c = '0;
        for (int c = 0; c < int'(COLORS); c++) begin
            for (int i = 0; i < int'(N_SIZE); i++) begin
                for (int j = 0; j < int'(N_SIZE); j++) begin
                    cnt_c[c] = cnt_c[c] + SUM_W'(win_d[i][j][c] & mask_c[i][j]);
                end
            end
            pix_c[c] = (cnt_c[c] >= n_threshold[c*SUM_W +: SUM_W])
                       && (mode_e'(mode) == MODE_COUNT || win_d[R][R][c]);
        end
    end

    always_comb begin
        out_valid_d = emit;
        out_pix_d   = emit ? pix_c : '0;
        out_x_d     = emit ? ox_q : '0;
        out_y_d     = emit ? oy_q : '0;
        out_sof_d   = emit && (ox_q == '0) && (oy_q == '0);
        out_eof_d   = emit && (ox_q == XW'(IMG_W - 1)) && (oy_q == YW'(IMG_H - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_x_q      <= '0;
            in_y_q      <= '0;
            prime_q     <= '0;
            flush_q     <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            in_x_q      <= in_x_d;
            in_y_q      <= in_y_d;
            prime_q     <= prime_d;
            flush_q     <= flush_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_stream_denoise.sv
// Scoreboard bench for stream_denoise: a neighbourhood-count reference model
// fills an expected queue per frame, the monitor fills a received queue.
module tb_stream_denoise;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int D  = 9;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [1:0] pix;
        logic       sof;
        logic       eof;
    } item_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [1:0] in_pix = '0;
    logic [7:0] n_threshold = '0;
    logic       mode = 1'b0;
    logic       in_ready, out_valid, out_sof, out_eof, busy;
    logic [1:0] out_pix;
    logic [2:0] out_x, out_y;

    int    tests_run = 0;
    int    tests_failed = 0;
    int    flush_cycles = 0;
    item_t exp_q[$];
    item_t got_q[$];
    logic [1:0] frame [H][W];

    always #5 clk = ~clk;

    stream_denoise #(
        .N_SIZE (3),
        .COLORS (2),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_pix      (in_pix),
        .n_threshold (n_threshold),
        .mode        (mode),
        .out_valid   (out_valid),
        .out_pix     (out_pix),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (out_valid) got_q.push_back(item_t'{out_x, out_y, out_pix, out_sof, out_eof});
        if (!in_ready) flush_cycles++;
    end

    function automatic item_t model_item(input int x, input int y);
        item_t it;
        int cnt;
        it.x = 3'(x);
        it.y = 3'(y);
        it.sof = (x == 0 && y == 0);
        it.eof = (x == W - 1 && y == H - 1);
        it.pix = '0;
        for (int c = 0; c < 2; c++) begin
            cnt = 0;
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                        cnt += int'(frame[y+dy][x+dx][c]);
            it.pix[c] = (cnt >= int'(n_threshold[c*4 +: 4])) && (!mode || frame[y][x][c]);
        end
        return it;
    endfunction

    task automatic push_expected(input int count);
        for (int k = 0; k < count; k++) exp_q.push_back(model_item(k % W, k / W));
    endtask

    task automatic send_beat(input logic [1:0] p, input logic s, input int gap_pct);
        for (int g = 0; g < 6 && int'($urandom_range(99)) < gap_pct; g++) begin
            in_valid = 1'b0;
            in_sof   = 1'($urandom);
            in_pix   = 2'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_sof   = s;
        in_pix   = p;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pix   = '0;
    endtask

    task automatic drive_frame(input int npix, input int gap_pct);
        for (int k = 0; k < npix; k++) send_beat(frame[k / W][k % W], k == 0, gap_pct);
    endtask

    task automatic fill_frame(input int kind);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                frame[y][x] = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b11 : 2'($urandom);
    endtask

    task automatic run_frame(input int gap_pct);
        exp_q.delete();
        got_q.delete();
        push_expected(W * H);
        drive_frame(W * H, gap_pct);
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: valid=%b sof=%b eof=%b expected 0 0 0", out_valid, out_sof, out_eof);
        end
        tests_run++;
        if (out_pix !== 2'b00 || out_x !== 3'd0 || out_y !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_data: pix=%b x=%0d y=%0d expected 00 0 0", out_pix, out_x, out_y);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_isolated;
        fill_frame(0);
        frame[3][4] = 2'b01;
        mode = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            n_threshold = {4'd1, (pass == 0) ? 4'd2 : 4'd1};
            run_frame(0);
            tests_run++;
            if (got_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL isolated_count: got %0d outputs expected %0d", got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                tests_run++;
                if (got_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL isolated[%0d] pass %0d: got %h expected %h", i, pass, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_all_ones;
        fill_frame(1);
        mode = 1'b0;
        n_threshold = {4'd0, 4'd9};
        run_frame(0);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL all_ones_count: got %0d outputs expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL all_ones[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gated;
        fill_frame(0);
        frame[2][2] = 2'b10;
        frame[2][3] = 2'b10;
        frame[2][4] = 2'b10;
        mode = 1'b1;
        n_threshold = {4'd2, 4'd0};
        run_frame(0);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL gated_count: got %0d outputs expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL gated[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_gaps;
        fill_frame(2);
        n_threshold = {4'd4, 4'd3};
        flush_cycles = 0;
        run_frame(50);
        tests_run++;
        if (flush_cycles != D) begin
            tests_failed++;
            $display("FAIL gaps_flush: in_ready low %0d cycles expected %0d", flush_cycles, D);
        end
        tests_run++;
        if (got_q.size() != W * H) begin
            tests_failed++;
            $display("FAIL gaps_count: got %0d outputs expected %0d", got_q.size(), W * H);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL gaps[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_restart;
        exp_q.delete();
        got_q.delete();
        n_threshold = {4'd2, 4'd3};
        fill_frame(2);
        push_expected(20 - D);
        drive_frame(20, 0);
        fill_frame(2);
        push_expected(W * H);
        drive_frame(W * H, 0);
        repeat (D + 6) @(negedge clk);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL restart_count: got %0d outputs expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL restart[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_flush;
        fill_frame(2);
        n_threshold = {4'd3, 4'd5};
        drive_frame(W * H, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_pix !== 2'b00 || out_eof !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_reset: valid=%b pix=%b eof=%b busy=%b expected 0 00 0 0",
                     out_valid, out_pix, out_eof, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_release: in_ready=%b busy=%b valid=%b expected 1 0 0", in_ready, busy, out_valid);
        end
        got_q.delete();
        for (int k = 0; k < 5; k++) send_beat(2'b11, 1'b0, 0);
        repeat (D + 4) @(negedge clk);
        tests_run++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_discard: got %0d outputs busy=%b expected 0 0", got_q.size(), busy);
        end
        run_frame(0);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL post_reset_count: got %0d outputs expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL post_reset[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_isolated();
        test_all_ones();
        test_gated();
        test_gaps();
        test_restart();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stream_denoise.md
STREAM_DENOISE -- requirements
Module: stream_denoise

Interface
REQ-001 Parameter N_SIZE, default 5, odd window edge length, >=3.
REQ-002 Parameter COLORS, default 1, independent 1-bit color planes per pixel.
REQ-003 Parameter IMG_W, default 640, pixels per line; IMG_H, default 480, lines per frame.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  pixel present; in_ready  output  1  block accepts; beat = in_valid&in_ready.
REQ-007 in_sof  input  1  marks pixel (0,0) of a frame; sampled only on a beat.
REQ-008 in_pix  input  COLORS  color mask of current pixel, raster order.
REQ-009 n_threshold  input  COLORS*SUM_W  per-color threshold, SUM_W=$clog2(N_SIZE*N_SIZE+1), color c at [c*SUM_W +: SUM_W].
REQ-010 mode  input  1  0=count-only, 1=center-gated.
REQ-011 out_valid  output  1  out_pix/out_x/out_y valid this cycle; no backpressure.
REQ-012 out_pix  output  COLORS; out_x  output  $clog2(IMG_W); out_y  output  $clog2(IMG_H).
REQ-013 out_sof, out_eof  output  1 each  first/last output pixel of frame; busy  output  1  state!=IDLE.

Function
REQ-014 States IDLE, RUN, FLUSH.
REQ-015 IDLE: in_ready=1; beat with in_sof=1 -> RUN, pixel stored as (0,0); beat with in_sof=0 discarded.
REQ-016 RUN: in_ready=1; each beat advances input x/y counters, x wraps at IMG_W-1 into y+1.
REQ-017 Beat delivering (IMG_W-1,IMG_H-1) -> FLUSH.
REQ-018 FLUSH: in_ready=0; block generates D=R*IMG_W+R internal zero beats, R=N_SIZE/2, one per cycle, then -> IDLE.
REQ-019 N_SIZE-1 line buffers of IMG_W x COLORS plus NxN window register shift once per beat (real or flush).
REQ-020 Window center for output (x,y) is complete on beat index k=y*IMG_W+x+D; out_valid asserted the cycle after that beat (latency 1 from completing beat).
REQ-021 Window positions outside frame (row<0, row>=IMG_H, col<0, col>=IMG_W) count as 0, never as stale or wrapped data.
REQ-022 count[c] = number of in-frame window pixels with bit c set, width SUM_W, no saturation needed.
REQ-023 mode 0: out_pix[c]=(count[c]>=thr[c]); mode 1: additionally requires center pixel bit c set.
REQ-024 thr[c]=0 in mode 0 yields out_pix[c]=1 for every output pixel.
REQ-025 Exactly IMG_W*IMG_H out_valid cycles per frame, raster order; out_sof with (0,0), out_eof with (IMG_W-1,IMG_H-1).
REQ-026 n_threshold and mode sampled with the completing beat; change mid-frame affects later pixels only.
REQ-027 in_sof on a RUN beat: partial frame discarded, no FLUSH, window/counters cleared, pixel taken as new (0,0); outputs of old frame stop.
REQ-028 Gaps in in_valid stall the pipeline; no output emitted without a completing beat.

Reset
REQ-029 reset_n low: state IDLE, all counters 0, window cleared, out_valid/out_sof/out_eof/out_pix/out_x/out_y=0, busy=0, in_ready=1 after release.
REQ-030 Line buffer contents need not be cleared; REQ-021 masking guarantees no leakage.
REQ-031 Reset mid-frame or mid-FLUSH aborts immediately; next frame requires in_sof.

Structure
REQ-032 Package denoise_pkg holds state enum, mode enum, SUM_W function.
REQ-033 One sub-module line_buffer (depth IMG_W, width COLORS, 1 write+1 read per beat, inferred RAM) instantiated N_SIZE-1 times.
REQ-034 Count adder tree and compare purely combinational between window and output register.

Verification (N_SIZE=3, COLORS=2, IMG_W=8, IMG_H=6, D=9)
REQ-035 Single isolated pixel color0 at (4,3), thr=2 mode 0 -> all out_pix=0; thr=1 -> 3x3 block around (4,3) color0=1.
REQ-036 All-ones frame, thr=9 mode 0 -> interior 1, all border pixels 0 (corner count 4, edge 6).
REQ-037 Center-gated: pixels (2,2),(3,2),(4,2) color1, thr=2 mode 1 -> out 1 only at those three positions.
REQ-038 Random in_valid gaps (50%) -> output identical to gapless run, 48 out_valid, out_eof at (7,5), in_ready=0 for exactly 9 flush cycles.
REQ-039 in_sof reasserted at pixel 20 -> old frame yields no out_eof; new frame full 48 outputs correct.
REQ-040 reset_n pulse during FLUSH -> outputs 0 next cycle, busy=0, subsequent frame correct.
